// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for the pipelined LEGv8 core.
// Two write ports (wr0 = ALU writeback, wr1 = load writeback), NUM_RD
// combinational read ports with optional same-cycle write-to-read bypass,
// and a per-register pending scoreboard used by the hazard unit.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   rd_addr / rd_data    packed read ports, port i at [i*W +: W]
//   rd_busy              per-port pending flag of the addressed register
//   wr0_* / wr1_*        write ports; wr1 wins on same-address conflict
//   sb_set_en/_addr      mark a register pending (producer issued)
//   flush                synchronous clear of all pending bits
module regfile_mp #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 3,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = 31,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     sb_set_en,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    input  logic                     flush
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    logic              wr0_ok;
    logic              wr1_ok;
    logic              set_ok;
    logic [ADDR_W-1:0] ra;
    logic              hit0;
    logic              hit1;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_EN != 0) && (a == ZERO_A);
    endfunction

    always_comb begin
        wr0_ok = wr0_en && !is_zero(wr0_addr);
        wr1_ok = wr1_en && !is_zero(wr1_addr);
        set_ok = sb_set_en && !is_zero(sb_set_addr);
    end

    // wr1 is applied after wr0 so it wins an address conflict.
    always_comb begin
        regs_d = regs_q;
        if (wr0_ok) regs_d[wr0_addr] = wr0_data;
        if (wr1_ok) regs_d[wr1_addr] = wr1_data;
    end

    // Clear, then set (new producer supersedes), then flush overrides all.
    always_comb begin
        pend_d = pend_q;
        if (wr0_ok) pend_d[wr0_addr] = 1'b0;
        if (wr1_ok) pend_d[wr1_addr] = 1'b0;
        if (set_ok) pend_d[sb_set_addr] = 1'b1;
        if (flush)  pend_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    // Read ports. Outputs are forced to zero while reset is held so that
    // bypassed write data cannot leak out during reset.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        hit0    = 1'b0;
        hit1    = 1'b0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            ra   = rd_addr[i*ADDR_W +: ADDR_W];
            hit0 = wr0_en && (wr0_addr == ra);
            hit1 = wr1_en && (wr1_addr == ra);
            if (reset || is_zero(ra)) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                rd_busy[i]                  = 1'b0;
            end else begin
                if ((BYPASS != 0) && hit1) begin
                    rd_data[i*DATA_W +: DATA_W] = wr1_data;
                end else if ((BYPASS != 0) && hit0) begin
                    rd_data[i*DATA_W +: DATA_W] = wr0_data;
                end else begin
                    rd_data[i*DATA_W +: DATA_W] = regs_q[ra];
                end
                // A forwarded write already supplies the data, so the
                // consumer need not wait on the pending bit.
                rd_busy[i] = pend_q[ra] && !((BYPASS != 0) && (hit0 || hit1));
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data_a, rd_data_b;
    logic [NR-1:0]    rd_busy_a, rd_busy_b;
    logic             wr0_en, wr1_en, sb_set_en, flush;
    logic [AW-1:0]    wr0_addr, wr1_addr, sb_set_addr;
    logic [DW-1:0]    wr0_data, wr1_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // DUT A: default configuration (bypass on, XZR hardwired)
    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_EN(1), .ZERO_IDX(31), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .flush(flush));

    // DUT B: bypass off, register 31 is an ordinary register
    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_EN(0), .ZERO_IDX(31), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .flush(flush));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr0_en = 0; wr1_en = 0; sb_set_en = 0; flush = 0;
    endtask

    task automatic set_ports(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        rd_addr = {a2, a1, a0};
    endtask

    task automatic test_reset();
        reset = 1; idle();
        wr0_addr = '0; wr0_data = '0; wr1_addr = '0; wr1_data = '0; sb_set_addr = '0;
        rd_addr = '0;
        #2;
        // Active write and set during reset must not reach the outputs.
        for (int a = 0; a < 32; a++) begin
            set_ports(AW'(a), AW'(31 - a), AW'(a));
            wr0_en = 1; wr0_addr = AW'(a); wr0_data = '1;
            sb_set_en = 1; sb_set_addr = AW'(a);
            #1;
            if ({rd_data_a, rd_data_b} !== '0) begin
                errors++; $display("FAIL reset_data addr=%0d got a=%h b=%h expected 0", a, rd_data_a, rd_data_b);
            end
            checks++;
            if ({rd_busy_a, rd_busy_b} !== '0) begin
                errors++; $display("FAIL reset_busy addr=%0d got a=%b b=%b expected 0", a, rd_busy_a, rd_busy_b);
            end
            checks++;
        end
        idle();
        step();
        reset = 0;
        step();
        // Writes attempted during reset were lost.
        set_ports(5'd0, 5'd5, 5'd30);
        #1;
        if ({rd_data_a, rd_data_b} !== '0) begin
            errors++; $display("FAIL post_reset_data got a=%h b=%h expected 0", rd_data_a, rd_data_b);
        end
        checks++;
        if ({rd_busy_a, rd_busy_b} !== '0) begin
            errors++; $display("FAIL post_reset_busy got a=%b b=%b expected 0", rd_busy_a, rd_busy_b);
        end
        checks++;
    endtask

    task automatic test_bypass();
        set_ports(5'd5, 5'd5, 5'd5);
        wr0_en = 1; wr0_addr = 5'd5; wr0_data = 64'h1234_5678_9ABC_DEF0;
        #1;
        if (rd_data_a !== {3{64'h1234_5678_9ABC_DEF0}}) begin
            errors++; $display("FAIL bypass_same_cycle_a got %h expected %h", rd_data_a, {3{64'h1234_5678_9ABC_DEF0}});
        end
        checks++;
        if (rd_data_b !== '0) begin
            errors++; $display("FAIL nobypass_same_cycle_b got %h expected 0", rd_data_b);
        end
        checks++;
        step(); idle(); #1;
        if (rd_data_a[1*DW +: DW] !== 64'h1234_5678_9ABC_DEF0) begin
            errors++; $display("FAIL stored_a got %h expected 123456789abcdef0", rd_data_a[1*DW +: DW]);
        end
        checks++;
        if (rd_data_b !== {3{64'h1234_5678_9ABC_DEF0}}) begin
            errors++; $display("FAIL stored_b got %h expected %h", rd_data_b, {3{64'h1234_5678_9ABC_DEF0}});
        end
        checks++;
    endtask

    task automatic test_conflict();
        set_ports(5'd5, 5'd7, 5'd0);
        wr0_en = 1; wr0_addr = 5'd7; wr0_data = 64'hAA;
        wr1_en = 1; wr1_addr = 5'd7; wr1_data = 64'hBB;
        #1;
        if (rd_data_a[1*DW +: DW] !== 64'hBB) begin
            errors++; $display("FAIL conflict_bypass_a got %h expected bb", rd_data_a[1*DW +: DW]);
        end
        checks++;
        if (rd_data_b[1*DW +: DW] !== 64'h0) begin
            errors++; $display("FAIL conflict_nobypass_b got %h expected 0", rd_data_b[1*DW +: DW]);
        end
        checks++;
        step(); idle(); #1;
        if (rd_data_a[1*DW +: DW] !== 64'hBB || rd_data_b[1*DW +: DW] !== 64'hBB) begin
            errors++; $display("FAIL conflict_stored got a=%h b=%h expected bb", rd_data_a[1*DW +: DW], rd_data_b[1*DW +: DW]);
        end
        checks++;
        // X5 unaffected by the X7 writes
        if (rd_data_a[0 +: DW] !== 64'h1234_5678_9ABC_DEF0) begin
            errors++; $display("FAIL conflict_x5_intact got %h expected 123456789abcdef0", rd_data_a[0 +: DW]);
        end
        checks++;
    endtask

    task automatic test_zero_reg();
        set_ports(5'd0, 5'd0, 5'd31);
        wr0_en = 1; wr0_addr = 5'd31; wr0_data = 64'hFFFF;
        #1;
        if (rd_data_a[2*DW +: DW] !== 64'h0 || rd_data_b[2*DW +: DW] !== 64'h0) begin
            errors++; $display("FAIL zero_same_cycle got a=%h b=%h expected 0", rd_data_a[2*DW +: DW], rd_data_b[2*DW +: DW]);
        end
        checks++;
        step(); idle();
        wr1_en = 1; wr1_addr = 5'd31; wr1_data = 64'hFFFF;
        step(); idle();
        sb_set_en = 1; sb_set_addr = 5'd31;
        #1;
        if (rd_data_a[2*DW +: DW] !== 64'h0) begin
            errors++; $display("FAIL zero_read_a got %h expected 0", rd_data_a[2*DW +: DW]);
        end
        checks++;
        if (rd_data_b[2*DW +: DW] !== 64'hFFFF) begin
            errors++; $display("FAIL x31_normal_b got %h expected ffff", rd_data_b[2*DW +: DW]);
        end
        checks++;
        step(); idle(); #1;
        if (rd_busy_a[2] !== 1'b0 || rd_data_a[2*DW +: DW] !== 64'h0) begin
            errors++; $display("FAIL zero_busy_a got busy=%b data=%h expected 0 0", rd_busy_a[2], rd_data_a[2*DW +: DW]);
        end
        checks++;
        if (rd_busy_b[2] !== 1'b1) begin
            errors++; $display("FAIL x31_busy_b got %b expected 1", rd_busy_b[2]);
        end
        checks++;
    endtask

    task automatic test_scoreboard();
        set_ports(5'd3, 5'd0, 5'd0);
        sb_set_en = 1; sb_set_addr = 5'd3;
        #1;
        if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b0) begin
            errors++; $display("FAIL sb_set_latency got a=%b b=%b expected 0", rd_busy_a[0], rd_busy_b[0]);
        end
        checks++;
        step(); idle(); #1;
        if (rd_busy_a[0] !== 1'b1 || rd_busy_b[0] !== 1'b1) begin
            errors++; $display("FAIL sb_set_seen got a=%b b=%b expected 1", rd_busy_a[0], rd_busy_b[0]);
        end
        checks++;
        wr1_en = 1; wr1_addr = 5'd3; wr1_data = 64'h55;
        sb_set_en = 1; sb_set_addr = 5'd3;
        #1;
        if (rd_busy_a[0] !== 1'b0 || rd_data_a[0 +: DW] !== 64'h55) begin
            errors++; $display("FAIL sb_mask_a got busy=%b data=%h expected 0 55", rd_busy_a[0], rd_data_a[0 +: DW]);
        end
        checks++;
        if (rd_busy_b[0] !== 1'b1 || rd_data_b[0 +: DW] !== 64'h0) begin
            errors++; $display("FAIL sb_nomask_b got busy=%b data=%h expected 1 0", rd_busy_b[0], rd_data_b[0 +: DW]);
        end
        checks++;
        step(); idle(); #1;
        if (rd_busy_a[0] !== 1'b1 || rd_busy_b[0] !== 1'b1) begin
            errors++; $display("FAIL sb_set_wins got a=%b b=%b expected 1", rd_busy_a[0], rd_busy_b[0]);
        end
        checks++;
        wr0_en = 1; wr0_addr = 5'd3; wr0_data = 64'h66;
        #1;
        if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b1) begin
            errors++; $display("FAIL sb_clear_same_cycle got a=%b b=%b expected 0 1", rd_busy_a[0], rd_busy_b[0]);
        end
        checks++;
        step(); idle(); #1;
        if (rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b0) begin
            errors++; $display("FAIL sb_cleared got a=%b b=%b expected 0", rd_busy_a[0], rd_busy_b[0]);
        end
        checks++;
        if (rd_data_b[0 +: DW] !== 64'h66) begin
            errors++; $display("FAIL sb_clear_data_b got %h expected 66", rd_data_b[0 +: DW]);
        end
        checks++;
    endtask

    task automatic test_flush();
        set_ports(5'd1, 5'd2, 5'd4);
        sb_set_en = 1; sb_set_addr = 5'd1; step();
        sb_set_addr = 5'd2; step();
        sb_set_addr = 5'd4; step();
        idle(); #1;
        if (rd_busy_a !== 3'b111 || rd_busy_b !== 3'b111) begin
            errors++; $display("FAIL flush_pre got a=%b b=%b expected 111", rd_busy_a, rd_busy_b);
        end
        checks++;
        flush = 1; sb_set_en = 1; sb_set_addr = 5'd6;
        step(); idle(); #1;
        if (rd_busy_a !== 3'b000 || rd_busy_b !== 3'b000) begin
            errors++; $display("FAIL flush_all got a=%b b=%b expected 000", rd_busy_a, rd_busy_b);
        end
        checks++;
        set_ports(5'd6, 5'd31, 5'd3);
        #1;
        if (rd_busy_a !== 3'b000 || rd_busy_b !== 3'b000) begin
            errors++; $display("FAIL flush_overrides_set got a=%b b=%b expected 000", rd_busy_a, rd_busy_b);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        set_ports(5'd10, 5'd11, 5'd10);
        wr0_en = 1; wr0_addr = 5'd10; wr0_data = 64'h1010;
        step();
        wr0_addr = 5'd11; wr0_data = 64'h1111;
        wr1_en = 1; wr1_addr = 5'd12; wr1_data = 64'h1212;
        #1;
        if (rd_data_b !== {64'h1010, 64'h0, 64'h1010}) begin
            errors++; $display("FAIL b2b_mid_b got %h expected %h", rd_data_b, {64'h1010, 64'h0, 64'h1010});
        end
        checks++;
        if (rd_data_a !== {64'h1010, 64'h1111, 64'h1010}) begin
            errors++; $display("FAIL b2b_mid_a got %h expected %h", rd_data_a, {64'h1010, 64'h1111, 64'h1010});
        end
        checks++;
        step(); idle();
        set_ports(5'd12, 5'd11, 5'd10);
        #1;
        if (rd_data_a !== {64'h1010, 64'h1111, 64'h1212} || rd_data_b !== {64'h1010, 64'h1111, 64'h1212}) begin
            errors++; $display("FAIL b2b_stored got a=%h b=%h expected %h", rd_data_a, rd_data_b, {64'h1010, 64'h1111, 64'h1212});
        end
        checks++;
    endtask

    task automatic test_async_reset();
        sb_set_en = 1; sb_set_addr = 5'd9;
        wr0_en = 1; wr0_addr = 5'd9; wr0_data = 64'h99;
        step(); idle();
        set_ports(5'd9, 5'd13, 5'd9);
        #1;
        if (rd_data_a[0 +: DW] !== 64'h99 || rd_busy_a[0] !== 1'b1) begin
            errors++; $display("FAIL arst_pre got data=%h busy=%b expected 99 1", rd_data_a[0 +: DW], rd_busy_a[0]);
        end
        checks++;
        #1;
        wr1_en = 1; wr1_addr = 5'd13; wr1_data = 64'hDEAD;
        sb_set_en = 1; sb_set_addr = 5'd13;
        reset = 1;
        #1;
        if ({rd_data_a, rd_data_b} !== '0 || {rd_busy_a, rd_busy_b} !== '0) begin
            errors++; $display("FAIL arst_immediate got a=%h b=%h busy=%b%b expected 0", rd_data_a, rd_data_b, rd_busy_a, rd_busy_b);
        end
        checks++;
        step(); idle();
        reset = 0;
        #1;
        if ({rd_data_a, rd_data_b} !== '0 || {rd_busy_a, rd_busy_b} !== '0) begin
            errors++; $display("FAIL arst_cleared got a=%h b=%h busy=%b%b expected 0", rd_data_a, rd_data_b, rd_busy_a, rd_busy_b);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_conflict();
        test_zero_reg();
        test_scoreboard();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined LEGv8 core. It replaces the single-write, two-read register file with configurable read ports and two write ports (ALU writeback and load writeback). It adds same-cycle write-to-read bypass and a per-register pending scoreboard, which the hazard unit uses to detect load-use and multi-cycle-producer dependencies. It sits between decode (read and scoreboard set) and writeback (write and scoreboard clear).

## Interface
- DATA_W, 64, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 3, number of read ports (≥1)
- ZERO_EN, 1, 1 = register ZERO_IDX is hardwired zero
- ZERO_IDX, 31, index of zero register (XZR)
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and pending bits
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  1 = register addressed by port i has pending bit set
- wr0_en / wr0_addr / wr0_data  in  1 / ADDR_W / DATA_W  write port 0 (ALU writeback)
- wr1_en / wr1_addr / wr1_data  in  1 / ADDR_W / DATA_W  write port 1 (load writeback)
- sb_set_en / sb_set_addr  in  1 / ADDR_W  mark register pending (producer issued)
- flush  in  1  synchronous clear of all pending bits (pipeline flush)

## Operation
- Storage: 2**ADDR_W × DATA_W registers, plus a 2**ADDR_W pending vector.
- Write: on a rising edge, each enabled port with a non-zero-register address writes its data to the register.
- Write conflict: wr0 and wr1 enabled to the same address → wr1 data is stored; wr0 is dropped.
- Zero register (ZERO_EN=1):
  - Reads of ZERO_IDX return 0.
  - Writes to ZERO_IDX are ignored.
  - sb_set to ZERO_IDX is ignored; its rd_busy is always 0.
  - ZERO_EN=0: ZERO_IDX behaves as a normal register.
- Read: combinational on rd_addr. Priority, highest first:
  - zero register → 0;
  - BYPASS=1 and wr1_en with matching address → wr1_data;
  - BYPASS=1 and wr0_en with matching address → wr0_data;
  - otherwise the stored value.
- Bypass off (BYPASS=0): a read in the same cycle as a write returns the old value.
- Scoreboard, per register, evaluated on a rising edge:
  - any write-port enable to the register clears its pending bit;
  - sb_set_en to the register sets its pending bit;
  - set and clear to the same register in the same cycle → set wins (a new producer supersedes);
  - flush clears every bit and overrides set and clear.
- rd_busy[i]: combinational from the pending bit of rd_addr[i].
  - BYPASS=1: rd_busy[i] is forced 0 when an enabled write port targets rd_addr[i] this cycle, since the data is already forwarded.
  - BYPASS=0: no such masking.
- Port independence: all read ports are independent; any number may address the same register.

## Timing
- Reset (asynchronous): all registers = 0, all pending bits = 0. While reset is high, rd_data = 0 and rd_busy = 0 for every address.
- Reset mid-operation: reset takes effect immediately; write and set inputs in that cycle are lost.
- Write latency: stored value is visible on the cycle after the edge; with BYPASS=1, visible in the same cycle combinationally.
- Scoreboard latency: a set is seen on rd_busy the cycle after sb_set_en. A clear is seen in the same cycle (BYPASS=1) or the next cycle (BYPASS=0).
- No internal stalls; every port is accepted every cycle.

## Test plan
- Reset then read every address on all ports → all rd_data = 0, rd_busy = 0.
- Write X5 = 0x1234_5678_9ABC_DEF0 via wr0 while reading X5 with BYPASS=1 → same-cycle rd_data = 0x1234_5678_9ABC_DEF0; next cycle still equal. With BYPASS=0 → same cycle 0, next cycle the value.
- wr0 X7 = 0xAA and wr1 X7 = 0xBB in the same cycle → read X7 returns 0xBB, both bypassed and stored.
- Write 0xFFFF to X31 via either port, then sb_set X31 → read X31 = 0, rd_busy = 0. Repeat with ZERO_EN=0 → reads 0xFFFF.
- sb_set X3; next cycle rd_busy = 1 on a port reading X3. Same cycle wr1 X3 = 0x55 plus sb_set X3 → rd_busy masked 0 that cycle, pending stays 1 after the edge. Then wr0 X3 alone → pending 0.
- Set pending on X1, X2, X4, then assert flush together with sb_set X6 → all pending bits 0, including X6. Assert reset asynchronously mid-cycle after writes → outputs 0 before the next edge.
